// File: rtl/synth_stereo_mixer.sv
// synth_stereo_mixer: per-voice gain/mute stereo mixer with saturate/wrap formatting and an output FIFO
module synth_stereo_mixer #(
  parameter int NUM_VOICES      = 16,
  parameter int SUBSAMPLE_WIDTH = 16,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int GAIN_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int DEFAULT_SHIFT   = 4,
  localparam int VW = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [SUBSAMPLE_WIDTH-1:0] i_Subsample,
  input  logic [VW-1:0]              i_SubsampleVoice,
  input  logic                       i_SubsampleReady,
  input  logic                       i_SampleReady,
  input  logic [15:0]                i_RegisterNumber,
  input  logic [15:0]                i_RegisterValue,
  input  logic                       i_RegisterWriteEnable,
  output logic                       o_SampleValid,
  input  logic                       i_SampleAccept,
  output logic [SAMPLE_WIDTH-1:0]    o_SampleLeft,
  output logic [SAMPLE_WIDTH-1:0]    o_SampleRight,
  output logic                       o_Clipped,
  output logic                       o_Overrun
);
  localparam int ACC = SUBSAMPLE_WIDTH + 1 + $clog2(NUM_VOICES) + 6;
  localparam int PW  = SUBSAMPLE_WIDTH + GAIN_WIDTH + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic signed [ACC-1:0] MAXV = {{(ACC-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC-1:0] MINV = ~MAXV;

  logic [GAIN_WIDTH-1:0]   gain_l [NUM_VOICES];
  logic [GAIN_WIDTH-1:0]   gain_r [NUM_VOICES];
  logic [NUM_VOICES-1:0]   mute;
  logic                    sat;
  logic [3:0]              shift;
  logic                    ctrl_wr, clr, clip, drop;
  logic [GAIN_WIDTH-1:0]   gl, gr;
  logic                    on;
  logic signed [PW-1:0]    prod_l, prod_r;
  logic signed [ACC-1:0]   p_l, p_r, acc_l, acc_r, total_l, total_r, sum_l, sum_r, y_l, y_r;
  logic                    s1, s2;
  logic [SAMPLE_WIDTH-1:0] fmt_l, fmt_r;
  logic [SAMPLE_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]           rd, wr;
  logic [AW:0]             count;
  logic                    full, pop, push;
  logic                    unused;

  assign unused = ^i_RegisterValue[15:8];

  // Stage 1 operand selection: registered gains give the old value on a same-cycle write
  always_comb begin
    on     = i_SubsampleReady && int'(i_SubsampleVoice) < NUM_VOICES && !mute[i_SubsampleVoice];
    gl     = gain_l[i_SubsampleVoice];
    gr     = gain_r[i_SubsampleVoice];
    prod_l = $signed(i_Subsample) * $signed({1'b0, gl});
    prod_r = $signed(i_Subsample) * $signed({1'b0, gr});
  end

  // Control/gain register file and sticky status flags
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        gain_l[i] <= GAIN_WIDTH'(1 << (GAIN_WIDTH-1));
        gain_r[i] <= GAIN_WIDTH'(1 << (GAIN_WIDTH-1));
      end
      mute      <= '0;
      sat       <= 1'b1;
      shift     <= 4'(DEFAULT_SHIFT);
      o_Clipped <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (i_RegisterWriteEnable && int'(i_RegisterNumber[15:11]) == i + 1 &&
            i_RegisterNumber[10:8] == 3'b111 && i_RegisterNumber[7:2] == '0) begin
          if (i_RegisterNumber[1:0] == 2'd0) gain_l[i] <= i_RegisterValue[GAIN_WIDTH-1:0];
          if (i_RegisterNumber[1:0] == 2'd1) gain_r[i] <= i_RegisterValue[GAIN_WIDTH-1:0];
          if (i_RegisterNumber[1:0] == 2'd2) mute[i]   <= i_RegisterValue[0];
        end
      if (ctrl_wr) begin
        sat   <= i_RegisterValue[0];
        shift <= i_RegisterValue[4:1];
      end
      o_Clipped <= (o_Clipped && !clr) || (s2 && clip);
      o_Overrun <= (o_Overrun && !clr) || drop;
    end
  end

  assign ctrl_wr = i_RegisterWriteEnable && i_RegisterNumber == 16'h0000;
  assign clr     = ctrl_wr && i_RegisterValue[5];

  // Pipeline: registered products, per-period accumulation, strobe delay line
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      p_l     <= '0;
      p_r     <= '0;
      acc_l   <= '0;
      acc_r   <= '0;
      total_l <= '0;
      total_r <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
    end else begin
      p_l   <= on ? ACC'(prod_l >>> (GAIN_WIDTH-1)) : '0;
      p_r   <= on ? ACC'(prod_r >>> (GAIN_WIDTH-1)) : '0;
      s1    <= i_SampleReady;
      s2    <= s1;
      acc_l <= s1 ? '0 : sum_l;
      acc_r <= s1 ? '0 : sum_r;
      if (s1) begin
        total_l <= sum_l;
        total_r <= sum_r;
      end
    end
  end

  // Output formatting: shift, then clamp or wrap, flagging out-of-range results
  always_comb begin
    sum_l = acc_l + p_l;
    sum_r = acc_r + p_r;
    y_l   = total_l >>> shift;
    y_r   = total_r >>> shift;
    clip  = y_l > MAXV || y_l < MINV || y_r > MAXV || y_r < MINV;
    fmt_l = sat && y_l > MAXV ? MAXV[SAMPLE_WIDTH-1:0] : sat && y_l < MINV ? MINV[SAMPLE_WIDTH-1:0] : y_l[SAMPLE_WIDTH-1:0];
    fmt_r = sat && y_r > MAXV ? MAXV[SAMPLE_WIDTH-1:0] : sat && y_r < MINV ? MINV[SAMPLE_WIDTH-1:0] : y_r[SAMPLE_WIDTH-1:0];
    full  = count == (AW+1)'(FIFO_DEPTH);
    pop   = i_SampleAccept && count != '0;
    push  = s2 && (!full || pop);
    drop  = s2 && full && !pop;
  end

  // Output FIFO; a full FIFO still accepts a push when the head is popped the same cycle
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem_l[wr] <= fmt_l;
        mem_r[wr] <= fmt_r;
        wr        <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign o_SampleValid = count != '0;
  assign o_SampleLeft  = mem_l[rd];
  assign o_SampleRight = mem_r[rd];
endmodule

// File: tb/tb_synth_stereo_mixer.sv
// tb_synth_stereo_mixer: directed self-checking bench for the stereo mixer
module tb_synth_stereo_mixer;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] sub = 0;
  logic [3:0]  voice = 0;
  logic        sub_rdy = 0, smp_rdy = 0;
  logic [15:0] reg_num = 0, reg_val = 0;
  logic        reg_we = 0, accept = 0;
  logic        valid, clipped, overrun;
  logic [15:0] left, right;
  int          errors = 0, checks = 0;

  synth_stereo_mixer dut (
    .i_Clock(clk), .i_Reset(rst), .i_Subsample(sub), .i_SubsampleVoice(voice),
    .i_SubsampleReady(sub_rdy), .i_SampleReady(smp_rdy), .i_RegisterNumber(reg_num),
    .i_RegisterValue(reg_val), .i_RegisterWriteEnable(reg_we), .o_SampleValid(valid),
    .i_SampleAccept(accept), .o_SampleLeft(left), .o_SampleRight(right),
    .o_Clipped(clipped), .o_Overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    reg_num = a; reg_val = v; reg_we = 1;
    tick;
    reg_we = 0;
  endtask

  task automatic send(input logic [3:0] vc, input logic [15:0] s, input logic strobe);
    voice = vc; sub = s; sub_rdy = 1; smp_rdy = strobe;
    tick;
    sub_rdy = 0; smp_rdy = 0;
  endtask

  task automatic pop;
    accept = 1;
    tick;
    accept = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    tick; tick;
    rst = 0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (left !== 16'd0 || right !== 16'd0) begin errors++; $display("FAIL reset_out got %0d/%0d want 0/0", left, right); end
    checks++; if (clipped !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", clipped, overrun); end
    wr(16'h0000, 16'h0001);
    send(0, 16'd1000, 1);
    tick;
    checks++; if (valid === 1'b1) begin errors++; $display("FAIL latency_early got valid at N+2 want N+3"); end
    tick;
    checks++; if (valid !== 1'b1 || left !== 16'd1000 || right !== 16'd1000) begin errors++; $display("FAIL unity got v=%b %0d/%0d want 1 1000/1000", valid, left, right); end
    pop;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pop_empty got %b want 0", valid); end
  endtask

  task automatic test_gain_mute;
    wr(16'h1F00, 16'd64);
    wr(16'h1F01, 16'd255);
    send(2, 16'd1000, 1);
    tick; tick;
    checks++; if (left !== 16'd500 || right !== 16'd1992) begin errors++; $display("FAIL gain got %0d/%0d want 500/1992", left, right); end
    pop;
    wr(16'h1F02, 16'd1);
    send(2, 16'd1000, 1);
    tick; tick;
    checks++; if (valid !== 1'b1 || left !== 16'd0 || right !== 16'd0) begin errors++; $display("FAIL mute got v=%b %0d/%0d want 1 0/0", valid, left, right); end
    pop;
    wr(16'h1F02, 16'd0);
    wr(16'h1F00, 16'd128);
    wr(16'h1F01, 16'd128);
    wr(16'h9700, 16'd0);
    wr(16'h1F03, 16'd0);
    send(2, 16'd300, 1);
    tick; tick;
    checks++; if (left !== 16'd300 || right !== 16'd300) begin errors++; $display("FAIL ignored_writes got %0d/%0d want 300/300", left, right); end
    pop;
  endtask

  task automatic test_sum_boundary;
    wr(16'h0000, 16'h0009);
    for (int v = 0; v < 16; v++) send(4'(v), 16'h7FFF, v == 15);
    tick; tick;
    checks++; if (left !== 16'd32767 || right !== 16'd32767) begin errors++; $display("FAIL sum16 got %0d/%0d want 32767/32767", left, right); end
    checks++; if (clipped !== 1'b0) begin errors++; $display("FAIL sum16_clip got %b want 0", clipped); end
    pop;
    wr(16'h0000, 16'h0001);
    send(0, 16'd100, 1);
    send(1, 16'd7, 0);
    smp_rdy = 1; tick; smp_rdy = 0;
    checks++; if (left !== 16'd100 || right !== 16'd100) begin errors++; $display("FAIL period1 got %0d/%0d want 100/100", left, right); end
    pop;
    tick;
    checks++; if (valid !== 1'b1 || left !== 16'd7) begin errors++; $display("FAIL period2 got v=%b %0d want 1 7", valid, left); end
    pop;
  endtask

  task automatic test_back_to_back;
    send(0, 16'd5, 1);
    send(1, 16'd9, 1);
    tick;
    checks++; if (left !== 16'd5) begin errors++; $display("FAIL b2b_first got %0d want 5", left); end
    pop;
    checks++; if (valid !== 1'b1 || left !== 16'd9) begin errors++; $display("FAIL b2b_second got v=%b %0d want 1 9", valid, left); end
    pop;
  endtask

  task automatic test_clip;
    send(0, 16'h7FFF, 0);
    send(1, 16'h7FFF, 1);
    tick; tick;
    checks++; if (left !== 16'h7FFF || right !== 16'h7FFF) begin errors++; $display("FAIL sat got %h/%h want 7fff/7fff", left, right); end
    checks++; if (clipped !== 1'b1) begin errors++; $display("FAIL sat_clip got %b want 1", clipped); end
    pop;
    wr(16'h0000, 16'h0021);
    checks++; if (clipped !== 1'b0) begin errors++; $display("FAIL clip_clear got %b want 0", clipped); end
    wr(16'h0000, 16'h0000);
    send(0, 16'h7FFF, 0);
    send(1, 16'h7FFF, 1);
    tick; tick;
    checks++; if (left !== 16'hFFFE || right !== 16'hFFFE) begin errors++; $display("FAIL wrap got %h/%h want fffe/fffe", left, right); end
    checks++; if (clipped !== 1'b1) begin errors++; $display("FAIL wrap_clip got %b want 1", clipped); end
    pop;
    wr(16'h0000, 16'h0021);
    checks++; if (clipped !== 1'b0) begin errors++; $display("FAIL clip_clear2 got %b want 0", clipped); end
  endtask

  task automatic test_fifo;
    logic [15:0] exp [4];
    exp[0] = 16'd20; exp[1] = 16'd30; exp[2] = 16'd40; exp[3] = 16'd60;
    for (int k = 1; k <= 5; k++) send(0, 16'(10 * k), 1);
    tick; tick;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun got %b want 1", overrun); end
    checks++; if (valid !== 1'b1 || left !== 16'd10) begin errors++; $display("FAIL full_head got v=%b %0d want 1 10", valid, left); end
    wr(16'h0000, 16'h0021);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
    send(0, 16'd60, 1);
    tick;
    pop;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pop_push_full overrun got %b want 0", overrun); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (valid !== 1'b1 || left !== exp[k]) begin errors++; $display("FAIL fifo_order[%0d] got v=%b %0d want 1 %0d", k, valid, left, exp[k]); end
      pop;
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL fifo_drained got %b want 0", valid); end
  endtask

  task automatic test_collision;
    voice = 0; sub = 16'd1000; sub_rdy = 1;
    reg_num = 16'h0F00; reg_val = 16'd64; reg_we = 1;
    tick;
    reg_we = 0; sub_rdy = 0;
    send(0, 16'd1000, 1);
    tick; tick;
    checks++; if (left !== 16'd1500 || right !== 16'd2000) begin errors++; $display("FAIL collision got %0d/%0d want 1500/2000", left, right); end
    pop;
    wr(16'h0F00, 16'd128);
  endtask

  task automatic test_reset_mid;
    send(0, 16'd500, 0);
    rst = 1; voice = 0; sub = 16'd300; sub_rdy = 1; smp_rdy = 1;
    tick;
    rst = 0; sub_rdy = 0; smp_rdy = 0;
    tick; tick; tick;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got %b want 0", valid); end
    wr(16'h0000, 16'h0001);
    send(0, 16'd77, 1);
    tick; tick;
    checks++; if (valid !== 1'b1 || left !== 16'd77 || right !== 16'd77) begin errors++; $display("FAIL reset_mid_acc got v=%b %0d/%0d want 1 77/77", valid, left, right); end
    pop;
  endtask

  initial begin
    test_reset;
    test_gain_mute;
    test_sum_boundary;
    test_back_to_back;
    test_clip;
    test_fifo;
    test_collision;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
